ifu: RTL and testbench

Instruction fetch unit for the single-issue RV64I core: owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a 2-entry queue. Sits directly upstream of the decode stage, presenting `instr`/`pc` over a valid/ready handshake. Accepts redirects (branch/jump/trap/mret target) from the execute stage.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_queue.sv | 53 +++++
 rtl/ifu.sv | 126 ++++++++++++
 tb/tb_ifu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Widths, reset PC, FSM state encodings and queue entry layout.
package ifu_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_WIDTH = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IFU_ST_REQ       = 2'd0,
    IFU_ST_WAIT      = 2'd1,
    IFU_ST_WAIT_KILL = 2'd2,
    IFU_ST_HALT      = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [XLEN-1:0]        pc;
    logic                   err;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Two-entry fetch queue holding {instr, pc, err}.
// Flush wins over push/pop; head reads as zero when empty.
module ifu_queue
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         valid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign valid   = (count != 2'd0);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointer/count bookkeeping and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetch PC, one outstanding imem
// request, 2-entry instruction queue toward decode.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ifu_imem_req_o,
  output logic [XLEN-1:0]        ifu_imem_addr_o,
  input  logic                   imem_ifu_gnt_i,
  input  logic                   imem_ifu_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_ifu_rdata_i,
  input  logic                   imem_ifu_err_i,
  input  logic                   ex_redirect_i,
  input  logic [XLEN-1:0]        ex_redirect_pc_i,
  output logic                   ifu_instr_valid_o,
  output logic [INSTR_WIDTH-1:0] ifu_instr_o,
  output logic [XLEN-1:0]        ifu_pc_o,
  output logic                   ifu_fetch_err_o,
  input  logic                   id_instr_ready_i
);

  ifu_state_e      state;
  ifu_state_e      state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_n;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] inflight_n;
  logic            push;
  logic            flush;
  logic            fire;
  logic            pending;
  logic [1:0]      count;
  fetch_entry_t    entry;
  fetch_entry_t    head;

  assign ifu_imem_req_o  = rst_n
                         & (state == IFU_ST_REQ)
                         & (count != 2'd2);
  assign ifu_imem_addr_o = fetch_pc;
  assign fire = ifu_imem_req_o & imem_ifu_gnt_i;

  // A request is still outstanding after this cycle.
  assign pending = fire
    | (((state == IFU_ST_WAIT)
      | (state == IFU_ST_WAIT_KILL))
      & ~imem_ifu_rvalid_i);

  assign entry.instr = imem_ifu_err_i ? '0
                                      : imem_ifu_rdata_i;
  assign entry.pc    = inflight_pc;
  assign entry.err   = imem_ifu_err_i;

  // Next-state, fetch PC and queue control.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    inflight_n = inflight_pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (ex_redirect_i) begin
      flush      = 1'b1;
      fetch_pc_n = word_align(ex_redirect_pc_i);
      state_n    = pending ? IFU_ST_WAIT_KILL
                           : IFU_ST_REQ;
    end else begin
      unique case (state)
        IFU_ST_REQ: begin
          if (fire) begin
            inflight_n = fetch_pc;
            fetch_pc_n = fetch_pc + XLEN'(4);
            state_n    = IFU_ST_WAIT;
          end
        end
        IFU_ST_WAIT: begin
          if (imem_ifu_rvalid_i) begin
            push    = 1'b1;
            state_n = imem_ifu_err_i ? IFU_ST_HALT
                                     : IFU_ST_REQ;
          end
        end
        IFU_ST_WAIT_KILL: begin
          if (imem_ifu_rvalid_i) begin
            state_n = IFU_ST_REQ;
          end
        end
        IFU_ST_HALT: begin
          state_n = IFU_ST_HALT;
        end
        default: state_n = IFU_ST_REQ;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IFU_ST_REQ;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      inflight_pc <= inflight_n;
    end
  end

  ifu_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (entry),
    .pop       (ifu_instr_valid_o & id_instr_ready_i),
    .valid     (ifu_instr_valid_o),
    .head      (head),
    .count     (count)
  );

  assign ifu_instr_o     = head.instr;
  assign ifu_pc_o        = head.pc;
  assign ifu_fetch_err_o = head.err;

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: directed scenarios then random traffic,
// checked against a transaction-level fetch/delivery model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        berr;
  logic        redir;
  logic [63:0] redir_pc;
  logic        ivalid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        ferr;
  logic        ready;

  ifu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ifu_imem_req_o    (req),
    .ifu_imem_addr_o   (addr),
    .imem_ifu_gnt_i    (gnt),
    .imem_ifu_rvalid_i (rvalid),
    .imem_ifu_rdata_i  (rdata),
    .imem_ifu_err_i    (berr),
    .ex_redirect_i     (redir),
    .ex_redirect_pc_i  (redir_pc),
    .ifu_instr_valid_o (ivalid),
    .ifu_instr_o       (instr),
    .ifu_pc_o          (pc),
    .ifu_fetch_err_o   (ferr),
    .id_instr_ready_i  (ready)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] RPC = 64'h8000_0000;

  typedef struct {
    logic [63:0] a;
    bit          live;
    int          cyc;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    bit          err;
  } exp_t;

  pend_t       pend[$];
  exp_t        expq[$];
  logic [63:0] exp_pc;
  bit          halted;
  bit          rdata_is_addr;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    expq.delete();
    exp_pc = RPC;
    halted = 1'b0;
  endtask

  // One cycle: check outputs, drive inputs, advance model.
  task automatic step(input bit g, input bit rv,
                      input bit rdy, input bit rd,
                      input logic [63:0] tgt,
                      input bit e);
    bit    exp_req;
    bit    fire;
    bit    rsp;
    bit    pop;
    pend_t p;
    exp_t  x;
    exp_req = !halted && pend.size() == 0
              && expq.size() < 2;
    chk("valid", ivalid, expq.size() != 0);
    if (expq.size() != 0) begin
      chk("pc", pc, expq[0].pc);
      chk("instr", instr, expq[0].instr);
      chk("ferr", ferr, expq[0].err);
    end
    chk("req", req, exp_req);
    if (exp_req) chk("addr", addr, exp_pc);
    gnt      = g;
    ready    = rdy;
    redir    = rd;
    redir_pc = tgt;
    rsp = rv && pend.size() != 0 && pend[0].cyc < cyc;
    rvalid = rsp;
    berr   = rsp ? e : 1'b0;
    if (rsp && rdata_is_addr) rdata = pend[0].a[31:0];
    else rdata = $urandom;
    fire = exp_req && g;
    pop  = expq.size() != 0 && rdy;
    if (rsp) p = pend.pop_front();
    if (pop) void'(expq.pop_front());
    if (rsp && p.live && !rd) begin
      x.instr = e ? 32'h0 : rdata;
      x.pc    = p.a;
      x.err   = e;
      expq.push_back(x);
      if (e) halted = 1'b1;
    end
    if (fire) begin
      pend.push_back('{exp_pc, !rd, cyc});
      if (!rd) exp_pc = exp_pc + 64'd4;
    end
    if (rd) begin
      expq.delete();
      foreach (pend[i]) pend[i].live = 1'b0;
      exp_pc = tgt & ~64'd3;
      halted = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10; i++) begin
      if (req) break;
      step(0, 1, 1, 0, 64'h0, 0);
    end
    chk("wait_req", req, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", req, 1'b0);
    chk("rst_valid", ivalid, 1'b0);
    chk("rst_addr", addr, RPC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [63:0] t;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    gnt = 0; rvalid = 0; rdata = 0; berr = 0;
    redir = 0; redir_pc = 0; ready = 0;
    rdata_is_addr = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_req", req, 1'b0);
    chk("reset_addr", addr, RPC);
    chk("reset_valid", ivalid, 1'b0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_pc", pc, 64'h0);
    chk("reset_ferr", ferr, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("first_req", req, 1'b1);
    // streaming, one instr per two cycles
    repeat (12) step(1, 1, 1, 0, 64'h0, 0);

    // queue fills, fetch stalls
    do_reset();
    repeat (10) step(1, 1, 0, 0, 64'h0, 0);
    chk("full_req", req, 1'b0);
    chk("full_pc", pc, RPC);
    step(0, 1, 1, 0, 64'h0, 0);
    chk("second_pc", pc, RPC + 64'd4);
    chk("resume_addr", addr, RPC + 64'd8);
    repeat (6) step(1, 1, 1, 0, 64'h0, 0);

    // redirect while waiting
    wait_req();
    step(1, 0, 1, 0, 64'h0, 0);
    step(0, 0, 1, 1, 64'h8000_1002, 0);
    step(0, 1, 1, 0, 64'h0, 0);
    chk("kill_valid", ivalid, 1'b0);
    chk("kill_addr", addr, 64'h8000_1000);
    step(1, 0, 1, 0, 64'h0, 0);
    step(0, 1, 1, 0, 64'h0, 0);
    chk("kill_first_pc", pc, 64'h8000_1000);

    // redirect in the grant cycle
    wait_req();
    step(0, 0, 1, 1, 64'h8000_0010, 0);
    chk("grant_addr", addr, 64'h8000_0010);
    step(1, 0, 1, 1, 64'h8000_0040, 0);
    step(0, 1, 1, 0, 64'h0, 0);
    chk("gr_drop_valid", ivalid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (ivalid) break;
      step(1, 1, 0, 0, 64'h0, 0);
    end
    chk("gr_first_pc", pc, 64'h8000_0040);

    // bus error halts fetch
    step(0, 0, 1, 1, 64'h8000_0008, 0);
    wait_req();
    step(1, 0, 0, 0, 64'h0, 0);
    step(0, 1, 0, 0, 64'h0, 1);
    chk("err_valid", ivalid, 1'b1);
    chk("err_pc", pc, 64'h8000_0008);
    chk("err_instr", instr, 32'h0);
    chk("err_flag", ferr, 1'b1);
    repeat (5) step(1, 1, 1, 0, 64'h0, 0);
    chk("halt_req", req, 1'b0);
    step(0, 0, 1, 1, 64'h8000_0100, 0);
    chk("restart_req", req, 1'b1);
    chk("restart_addr", addr, 64'h8000_0100);

    // wrap around top of address space
    step(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    chk("wrap_addr0", addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, 0, 64'h0, 0);
    step(0, 1, 0, 0, 64'h0, 0);
    chk("wrap_addr1", addr, 64'h0);
    chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_ferr", ferr, 1'b0);
    repeat (6) step(1, 1, 1, 0, 64'h0, 0);

    // random traffic
    rdata_is_addr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if ($urandom_range(0, 3) == 0)
        t = 64'hFFFF_FFFF_FFFF_FFF0
            | 64'($urandom_range(0, 15));
      else
        t = {$urandom, $urandom};
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0,
           t,
           $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
